// File: rtl/l2_responder_if.sv
// Shared operation type and the word request/response bundle between the
// dcache fill/flush sequencer (master) and the L2 responder (slave).

package xentry_pkg;
  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    STORE      = 2'd1,
    MO_UNKNOWN = 2'd2
  } memory_operation_e;
endpackage

interface l2_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
);
  import xentry_pkg::*;

  logic              req_valid;
  memory_operation_e req_type;
  logic [ADDR_W-1:0] req_address;
  logic [WORD_W-1:0] req_store_word;
  logic              req_fulfilled;
  logic [WORD_W-1:0] req_load_word;

  modport master (
    output req_valid, req_type, req_address, req_store_word,
    input  req_fulfilled, req_load_word
  );

  modport slave (
    input  req_valid, req_type, req_address, req_store_word,
    output req_fulfilled, req_load_word
  );
endinterface

// File: rtl/l2_responder.sv
// Word-granular L2 stand-in: accepts one LOAD/STORE per handshake, waits a
// fixed latency, then pulses req_fulfilled and commits/returns the word.

module l2_responder
  import xentry_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input  logic         clk,
  input  logic         reset,
  l2_responder_if.slave bus,
  output logic         busy,
  output logic         protocol_error
);

  localparam int unsigned OFF_W = $clog2(WORD_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  memory_operation_e type_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] load_word_q;
  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Byte offset bits dropped, high bits beyond the array wrap silently.
  logic [IDX_W-1:0] in_idx;
  assign in_idx = bus.req_address[OFF_W +: IDX_W];

  logic unused_addr;
  assign unused_addr = ^bus.req_address;

  function automatic logic type_known(input memory_operation_e t);
    case (t)
      LOAD, STORE: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  // The load word is registered on the edge that enters ST_RESPOND, so it is
  // valid throughout the pulse cycle; with LATENCY=1 that edge is the
  // acceptance edge, so the live request is used instead of the capture.
  logic              enter_respond;
  memory_operation_e rd_type;
  logic [IDX_W-1:0]  rd_idx;

  // Select which request the upcoming response reads for.
  always_comb begin
    enter_respond = 1'b0;
    rd_type       = type_q;
    rd_idx        = idx_q;
    case (state)
      ST_IDLE: begin
        if (LATENCY == 1 && bus.req_valid) begin
          enter_respond = 1'b1;
          rd_type       = bus.req_type;
          rd_idx        = in_idx;
        end
      end
      ST_WAIT: begin
        if (cnt <= CNT_W'(1)) enter_respond = 1'b1;
      end
      default: ;
    endcase
  end

  // Transaction sequencing, capture, load-word register and error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      type_q         <= LOAD;
      idx_q          <= '0;
      wdata_q        <= '0;
      load_word_q    <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (enter_respond) begin
        case (rd_type)
          LOAD:    load_word_q <= mem[rd_idx];
          STORE:   ;
          default: load_word_q <= '0;
        endcase
      end
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            type_q  <= bus.req_type;
            idx_q   <= in_idx;
            wdata_q <= bus.req_store_word;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= (LATENCY == 1) ? ST_RESPOND : ST_WAIT;
            if (!type_known(bus.req_type)) protocol_error <= 1'b1;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (enter_respond) state <= ST_RESPOND;
          if (!bus.req_valid) protocol_error <= 1'b1;
        end
        ST_RESPOND: state <= ST_IDLE;
        default: begin
          state       <= ST_IDLE;
          load_word_q <= 'x;
        end
      endcase
    end
  end

  // Store commit on the edge that ends ST_RESPOND; array is never reset.
  always_ff @(posedge clk) begin
    if (state == ST_RESPOND && type_q == STORE) mem[idx_q] <= wdata_q;
  end

  // State-decoded handshake outputs.
  always_comb begin
    bus.req_fulfilled = 1'b0;
    busy              = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_WAIT: busy = 1'b1;
      ST_RESPOND: begin
        bus.req_fulfilled = 1'b1;
        busy              = 1'b1;
      end
      default: begin
        bus.req_fulfilled = 1'bx;
        busy              = 1'bx;
      end
    endcase
  end

  assign bus.req_load_word = load_word_q;

endmodule

// File: tb/tb_l2_responder.sv
// Randomized and directed bench for l2_responder (LATENCY=4 and LATENCY=1
// instances) against a word-array reference model.

module tb_l2_responder;
  import xentry_pkg::*;

  localparam int LAT4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic busy4, perr4, busy1, perr1;

  l2_responder_if #(.ADDR_W(32), .WORD_W(32)) b4 ();
  l2_responder_if #(.ADDR_W(32), .WORD_W(32)) b1 ();

  l2_responder #(.ADDR_W(32), .WORD_W(32), .DEPTH_WORDS(1024), .LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4.slave), .busy(busy4), .protocol_error(perr4)
  );

  l2_responder #(.ADDR_W(32), .WORD_W(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave), .busy(busy1), .protocol_error(perr1)
  );

  int checks = 0;
  int errors = 0;

  bit [31:0] model4 [int];
  bit [31:0] model1 [int];

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd1024);
  endfunction

  task automatic drive4(input memory_operation_e t, input logic [31:0] a, input logic [31:0] d);
    b4.req_valid = 1'b1; b4.req_type = t; b4.req_address = a; b4.req_store_word = d;
  endtask

  task automatic drive1(input memory_operation_e t, input logic [31:0] a, input logic [31:0] d);
    b1.req_valid = 1'b1; b1.req_type = t; b1.req_address = a; b1.req_store_word = d;
  endtask

  task automatic wait4(output int lat, output logic [31:0] rd, output bit to);
    lat = 0; to = 1'b1; rd = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (b4.req_fulfilled === 1'b1) begin
        rd = b4.req_load_word; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait1(output int lat, output logic [31:0] rd, output bit to);
    lat = 0; to = 1'b1; rd = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (b1.req_fulfilled === 1'b1) begin
        rd = b1.req_load_word; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    b4.req_valid = 1'b0; b1.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    b4.req_valid = 1'b0; b4.req_type = LOAD; b4.req_address = '0; b4.req_store_word = '0;
    b1.req_valid = 1'b0; b1.req_type = LOAD; b1.req_address = '0; b1.req_store_word = '0;
    repeat (2) @(negedge clk);
    checks += 8;
    if (b4.req_fulfilled !== 1'b0) begin errors++; $display("FAIL rst_ful4: got %b expected 0", b4.req_fulfilled); end
    if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy4: got %b expected 0", busy4); end
    if (b4.req_load_word !== 32'h0) begin errors++; $display("FAIL rst_lw4: got %h expected 0", b4.req_load_word); end
    if (perr4 !== 1'b0) begin errors++; $display("FAIL rst_perr4: got %b expected 0", perr4); end
    if (b1.req_fulfilled !== 1'b0) begin errors++; $display("FAIL rst_ful1: got %b expected 0", b1.req_fulfilled); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy1: got %b expected 0", busy1); end
    if (b1.req_load_word !== 32'h0) begin errors++; $display("FAIL rst_lw1: got %h expected 0", b1.req_load_word); end
    if (perr1 !== 1'b0) begin errors++; $display("FAIL rst_perr1: got %b expected 0", perr1); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; bit to;
    drive4(STORE, 32'h40, 32'hDEADBEEF);
    wait4(lat, rd, to);
    model4[widx(32'h40)] = 32'hDEADBEEF;
    checks += 2;
    if (to || lat != LAT4) begin errors++; $display("FAIL st_lat: got %0d (timeout %0d) expected %0d", lat, to, LAT4); end
    if (busy4 !== 1'b1) begin errors++; $display("FAIL st_busy: got %b expected 1", busy4); end
    b4.req_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (b4.req_fulfilled !== 1'b0) begin errors++; $display("FAIL st_width: got %b expected 0", b4.req_fulfilled); end
    if (busy4 !== 1'b0) begin errors++; $display("FAIL st_idle_busy: got %b expected 0", busy4); end
    drive4(LOAD, 32'h40, 32'h0);
    wait4(lat, rd, to);
    checks += 2;
    if (to || lat != LAT4) begin errors++; $display("FAIL ld_lat: got %0d (timeout %0d) expected %0d", lat, to, LAT4); end
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_data: got %h expected deadbeef", rd); end
    b4.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b4.req_load_word !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_hold: got %h expected deadbeef", b4.req_load_word); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; bit to;
    logic [31:0] a;
    for (int k = 0; k < 8; k++) begin
      a = 32'h100 + 32'(4 * (k % 4));
      if (k < 4) drive4(STORE, a, 32'(k + 1));
      else       drive4(LOAD, a, 32'h0);
      wait4(lat, rd, to);
      checks++;
      if (to || lat != ((k == 0) ? LAT4 : LAT4 + 1)) begin
        errors++; $display("FAIL b2b_lat[%0d]: got %0d (timeout %0d) expected %0d", k, lat, to, (k == 0) ? LAT4 : LAT4 + 1);
      end
      if (k < 4) model4[widx(a)] = 32'(k + 1);
      else begin
        checks++;
        if (rd !== model4[widx(a)]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, rd, model4[widx(a)]); end
      end
    end
    b4.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; bit to;
    drive4(STORE, 32'h0000_1000, 32'hA5);
    wait4(lat, rd, to);
    model4[widx(32'h0000_1000)] = 32'hA5;
    b4.req_valid = 1'b0;
    @(negedge clk);
    drive4(LOAD, 32'h0, 32'h0);
    wait4(lat, rd, to);
    checks += 2;
    if (to) begin errors++; $display("FAIL wrap_to: no pulse within bound"); end
    if (rd !== 32'hA5) begin errors++; $display("FAIL wrap_data: got %h expected a5", rd); end
    b4.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency1();
    int lat; logic [31:0] rd; bit to;
    drive1(STORE, 32'h40, 32'h1234_5678);
    wait1(lat, rd, to);
    model1[widx(32'h40)] = 32'h1234_5678;
    checks++;
    if (to || lat != 1) begin errors++; $display("FAIL l1_st_lat: got %0d (timeout %0d) expected 1", lat, to); end
    drive1(LOAD, 32'h40, 32'h0);
    wait1(lat, rd, to);
    checks += 2;
    if (to || lat != 2) begin errors++; $display("FAIL l1_b2b_lat: got %0d (timeout %0d) expected 2", lat, to); end
    if (rd !== model1[widx(32'h40)]) begin errors++; $display("FAIL l1_data: got %h expected %h", rd, model1[widx(32'h40)]); end
    b1.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b1.req_fulfilled !== 1'b0) begin errors++; $display("FAIL l1_width: got %b expected 0", b1.req_fulfilled); end
    drive1(LOAD, 32'h40, 32'h0);
    wait1(lat, rd, to);
    checks += 2;
    if (to || lat != 1) begin errors++; $display("FAIL l1_ld_lat: got %0d (timeout %0d) expected 1", lat, to); end
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL l1_ld_data: got %h expected 12345678", rd); end
    b1.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; bit to;
    memory_operation_e t;
    logic [31:0] a, d;
    bit b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      t = ($urandom_range(0, 1) == 1) ? STORE : LOAD;
      a = (32'($urandom_range(0, 3)) << 12) | ((32'($urandom_range(0, 15)) + 32'd512) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      drive4(t, a, d);
      wait4(lat, rd, to);
      checks++;
      if (to || lat != (b2b ? LAT4 + 1 : LAT4)) begin
        errors++; $display("FAIL rnd_lat[%0d]: got %0d (timeout %0d) expected %0d", i, lat, to, b2b ? LAT4 + 1 : LAT4);
      end
      if (t == STORE) model4[widx(a)] = d;
      else if (model4.exists(widx(a))) begin
        checks++;
        if (rd !== model4[widx(a)]) begin errors++; $display("FAIL rnd_data[%0d]: addr %h got %h expected %h", i, a, rd, model4[widx(a)]); end
      end
      b2b = ($urandom_range(0, 1) == 1);
      if (!b2b) begin
        b4.req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    b4.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (perr4 !== 1'b0) begin errors++; $display("FAIL rnd_perr: got %b expected 0", perr4); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; bit to;
    apply_reset();
    drive4(STORE, 32'h304, 32'h3333_3333);
    @(negedge clk);
    checks++;
    if (perr4 !== 1'b0) begin errors++; $display("FAIL drop_pre: got %b expected 0", perr4); end
    b4.req_valid = 1'b0;
    wait4(lat, rd, to);
    model4[widx(32'h304)] = 32'h3333_3333;
    checks += 2;
    if (to || lat != LAT4 - 1) begin errors++; $display("FAIL drop_lat: got %0d (timeout %0d) expected %0d", lat, to, LAT4 - 1); end
    if (perr4 !== 1'b1) begin errors++; $display("FAIL drop_perr: got %b expected 1", perr4); end
    @(negedge clk);
    drive4(LOAD, 32'h304, 32'h0);
    wait4(lat, rd, to);
    checks++;
    if (rd !== 32'h3333_3333) begin errors++; $display("FAIL drop_data: got %h expected 33333333", rd); end
    b4.req_valid = 1'b0;
    apply_reset();
    checks++;
    if (perr4 !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b expected 0", perr4); end
    drive4(STORE, 32'h300, 32'h1111_1111);
    wait4(lat, rd, to);
    model4[widx(32'h300)] = 32'h1111_1111;
    b4.req_valid = 1'b0;
    @(negedge clk);
    drive4(MO_UNKNOWN, 32'h300, 32'h2222_2222);
    wait4(lat, rd, to);
    checks += 3;
    if (to || lat != LAT4) begin errors++; $display("FAIL unk_lat: got %0d (timeout %0d) expected %0d", lat, to, LAT4); end
    if (rd !== 32'h0) begin errors++; $display("FAIL unk_lw: got %h expected 0", rd); end
    if (perr4 !== 1'b1) begin errors++; $display("FAIL unk_perr: got %b expected 1", perr4); end
    b4.req_valid = 1'b0;
    @(negedge clk);
    drive4(LOAD, 32'h300, 32'h0);
    wait4(lat, rd, to);
    checks += 2;
    if (rd !== model4[widx(32'h300)]) begin errors++; $display("FAIL unk_nowrite: got %h expected %h", rd, model4[widx(32'h300)]); end
    if (perr4 !== 1'b1) begin errors++; $display("FAIL unk_sticky: got %b expected 1", perr4); end
    b4.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; bit to;
    int pulses;
    apply_reset();
    drive4(STORE, 32'h400, 32'h5555_5555);
    wait4(lat, rd, to);
    model4[widx(32'h400)] = 32'h5555_5555;
    b4.req_valid = 1'b0;
    @(negedge clk);
    drive4(STORE, 32'h400, 32'h6666_6666);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks += 2;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy4); end
    if (b4.req_load_word !== 32'h0) begin errors++; $display("FAIL rmid_lw: got %h expected 0", b4.req_load_word); end
    b4.req_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b4.req_fulfilled !== 1'b0) pulses++;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (b4.req_fulfilled !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rmid_pulse: got %0d pulses expected 0", pulses); end
    drive4(LOAD, 32'h400, 32'h0);
    wait4(lat, rd, to);
    checks += 2;
    if (to || lat != LAT4) begin errors++; $display("FAIL rmid_lat: got %0d (timeout %0d) expected %0d", lat, to, LAT4); end
    if (rd !== model4[widx(32'h400)]) begin errors++; $display("FAIL rmid_old: got %h expected %h", rd, model4[widx(32'h400)]); end
    b4.req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_wrap();
    test_latency1();
    test_random();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
